// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Follows each read grant down the two-stage return pipeline.
    typedef struct packed {
        logic valid;
        logic port;
        logic in_range;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_NONE = '{valid: 1'b0, port: 1'b0, in_range: 1'b0};

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Fetch port, load/store port and memory-side signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic              lock1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              lock_abort;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0, addr0, req1, we1, lock1, addr1, wdata1, mem_rdata,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, lock_abort,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, addr0, req1, we1, lock1, addr1, wdata1, mem_rdata,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, lock_abort,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - Two-requester round-robin picker with a forceable last pointer.
module mem_port_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       force_last1,
    output logic       win_valid,
    output logic       win_port
);
    logic last;

    always_comb begin
        win_valid = |elig;
        if (&elig) begin
            win_port = ~last;
        end else begin
            win_port = elig[1];
        end
    end

    // Forcing last to port 1 hands the next tie to port 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (force_last1) begin
            last <= 1'b1;
        end else if (win_valid) begin
            last <= win_port;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares one synchronous memory between fetch and load/store ports.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 32,
    parameter int LOCK_MAX  = 8
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    lock_state_e       lock_state;
    logic [CNT_W-1:0]  lock_cnt;
    rd_tag_t           tag_a;
    rd_tag_t           tag_b;

    logic [1:0]        elig;
    logic              win_valid;
    logic              win_port;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic              win_in_range;
    logic              locked;
    logic              lock_take;
    logic              lock_release;
    logic              lock_expire;
    logic [DATA_W-1:0] ret_data;

    assign locked  = (lock_state == LOCKED);
    // A port whose grant is high cannot win again, so a slow req drop never double-issues.
    assign elig[0] = bus.req0 && !bus.gnt0 && !locked;
    assign elig[1] = bus.req1 && !bus.gnt1;

    mem_port_arbiter_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .elig        (elig),
        .force_last1 (lock_expire),
        .win_valid   (win_valid),
        .win_port    (win_port)
    );

    always_comb begin
        win_addr     = win_port ? bus.addr1 : bus.addr0;
        win_we       = win_port && bus.we1;
        win_in_range = ({1'b0, win_addr} < DEPTH_L);
        lock_take    = !locked && win_valid && win_port && bus.lock1;
        lock_release = locked && win_valid && win_port && !bus.lock1;
        lock_expire  = locked && !lock_release && (lock_cnt == CNT_W'(LOCK_MAX - 1));
        ret_data     = tag_b.in_range ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state     <= UNLOCKED;
            lock_cnt       <= '0;
            bus.lock_abort <= 1'b0;
        end else begin
            bus.lock_abort <= lock_expire;
            if (lock_take) begin
                lock_state <= LOCKED;
                lock_cnt   <= '0;
            end else if (locked) begin
                lock_cnt <= lock_cnt + 1'b1;
                if (lock_release || lock_expire) begin
                    lock_state <= UNLOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
            tag_a         <= RD_TAG_NONE;
            tag_b         <= RD_TAG_NONE;
        end else begin
            bus.gnt0   <= win_valid && (win_port == PORT_FETCH);
            bus.gnt1   <= win_valid && (win_port == PORT_DATA);
            bus.mem_en <= win_valid && win_in_range;
            bus.mem_we <= win_valid && win_we && win_in_range;
            if (win_valid) begin
                bus.mem_addr <= win_addr;
                if (win_port == PORT_DATA) begin
                    bus.mem_wdata <= bus.wdata1;
                end
            end
            // Out-of-range reads still return, with zero data.
            tag_a <= '{valid: win_valid && !win_we, port: win_port, in_range: win_in_range};
            tag_b <= tag_a;
            bus.rvalid0 <= tag_b.valid && (tag_b.port == PORT_FETCH);
            bus.rvalid1 <= tag_b.valid && (tag_b.port == PORT_DATA);
            if (tag_b.valid) begin
                if (tag_b.port == PORT_DATA) begin
                    bus.rdata1 <= ret_data;
                end else begin
                    bus.rdata0 <= ret_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 32;
    localparam int LOCK_MAX  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];

    // Reference model state: what each output should show in the current cycle.
    logic        m_gnt0, m_gnt1, m_en, m_we, m_rv0, m_rv1, m_abort, m_locked;
    logic [11:0] m_addr;
    logic [31:0] m_wdata, m_rdata0, m_rdata1;
    int          m_last, m_lock_cycles, cyc;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } ret_t;
    ret_t m_ret[$];

    task automatic model_reset();
        m_gnt0 = 0; m_gnt1 = 0; m_en = 0; m_we = 0; m_rv0 = 0; m_rv1 = 0;
        m_abort = 0; m_locked = 0; m_addr = 0; m_wdata = 0; m_rdata0 = 0; m_rdata1 = 0;
        m_last = 1; m_lock_cycles = 0;
        m_ret.delete();
    endtask

    task automatic model_step();
        bit          e0, e1, inr, wr;
        int          win;
        logic [11:0] a;
        ret_t        r;
        if (rst) begin
            model_reset();
            return;
        end
        cyc++;
        e0  = bus.req0 && !m_gnt0 && !m_locked;
        e1  = bus.req1 && !m_gnt1;
        win = -1;
        if (e0 && e1) win = (m_last == 1) ? 0 : 1;
        else if (e0)  win = 0;
        else if (e1)  win = 1;
        m_abort = 0;
        if (m_locked) begin
            m_lock_cycles++;
            if (win == 1 && !bus.lock1) m_locked = 0;
            else if (m_lock_cycles == LOCK_MAX) begin
                m_locked = 0;
                m_abort  = 1;
            end
        end else if (win == 1 && bus.lock1) begin
            m_locked      = 1;
            m_lock_cycles = 0;
        end
        if (win >= 0) m_last = win;
        if (m_abort)  m_last = 1;
        m_gnt0 = (win == 0);
        m_gnt1 = (win == 1);
        m_en   = 0;
        m_we   = 0;
        if (win >= 0) begin
            a   = (win == 1) ? bus.addr1 : bus.addr0;
            inr = (a < MEM_DEPTH);
            wr  = (win == 1) && bus.we1;
            m_addr = a;
            if (win == 1) m_wdata = bus.wdata1;
            m_en = inr;
            m_we = wr && inr;
            if (wr) begin
                if (inr) ref_mem[a[4:0]] = bus.wdata1;
            end else begin
                r.due  = cyc + 2;
                r.port = win;
                r.data = inr ? ref_mem[a[4:0]] : 32'h0;
                m_ret.push_back(r);
            end
        end
        m_rv0 = 0;
        m_rv1 = 0;
        if (m_ret.size() > 0 && m_ret[0].due == cyc) begin
            r = m_ret.pop_front();
            if (r.port == 0) begin m_rv0 = 1; m_rdata0 = r.data; end
            else             begin m_rv1 = 1; m_rdata1 = r.data; end
        end
    endtask

    // One clock: memory acts on the strobes of the cycle just ended, data settles mid-cycle.
    task automatic cycle();
        logic        en, we;
        logic [11:0] a;
        logic [31:0] d;
        en = bus.mem_en; we = bus.mem_we; a = bus.mem_addr; d = bus.mem_wdata;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (en === 1'b1) begin
            if (we === 1'b1) mem[a[4:0]] = d;
            else             bus.mem_rdata = mem[a[4:0]];
        end
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.addr0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.mem_rdata = 0;
        rst = 1;
        cycle();
        cycle();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we, bus.lock_abort} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000000",
                     {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we, bus.lock_abort});
        end
        checks++;
        if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata);
        end
        rst = 0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        mem[5] = 32'h3200_0007; ref_mem[5] = 32'h3200_0007;
        bus.req0 = 1; bus.addr0 = 5;
        cycle();
        bus.req0 = 0;
        checks++;
        if ({bus.gnt0, bus.mem_en, bus.mem_we} !== 3'b110 || bus.mem_addr !== 12'd5) begin
            errors++;
            $display("FAIL fetch_grant got gnt0/en/we=%b addr=%0d exp 110 addr=5",
                     {bus.gnt0, bus.mem_en, bus.mem_we}, bus.mem_addr);
        end
        cycle();
        checks++;
        if (bus.rvalid0 !== 1'b0) begin
            errors++; $display("FAIL fetch_early_rvalid got %b exp 0", bus.rvalid0);
        end
        cycle();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h3200_0007) begin
            errors++; $display("FAIL fetch_return got rvalid0=%b rdata0=%h exp 1 32000007", bus.rvalid0, bus.rdata0);
        end
    endtask

    task automatic test_alternate();
        logic ev0, ev1;
        do_reset();
        mem[1] = 32'd6; ref_mem[1] = 32'd6;
        bus.req0 = 1; bus.addr0 = 5;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            ev0 = (i >= 2) && (i % 2 == 0);
            ev1 = (i >= 3) && (i % 2 == 1);
            checks++;
            if (bus.gnt0 !== (i % 2 == 0) || bus.gnt1 !== (i % 2 == 1)) begin
                errors++; $display("FAIL alt_grant[%0d] got %b%b exp %b%b", i, bus.gnt0, bus.gnt1, i % 2 == 0, i % 2 == 1);
            end
            checks++;
            if (bus.rvalid0 !== ev0 || bus.rvalid1 !== ev1
                || (ev0 && bus.rdata0 !== 32'h3200_0007) || (ev1 && bus.rdata1 !== 32'd6)) begin
                errors++;
                $display("FAIL alt_return[%0d] got rv=%b%b rd0=%h rd1=%h exp rv=%b%b rd0=32000007 rd1=6",
                         i, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1, ev0, ev1);
            end
        end
        idle_inputs();
        repeat (3) cycle();
    endtask

    task automatic test_write_read();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 2; bus.wdata1 = 32'h30;
        cycle();
        checks++;
        if ({bus.gnt1, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_wdata !== 32'h30 || bus.mem_addr !== 12'd2) begin
            errors++;
            $display("FAIL wr_grant got gnt1/en/we=%b wdata=%h addr=%0d exp 111 30 2",
                     {bus.gnt1, bus.mem_en, bus.mem_we}, bus.mem_wdata, bus.mem_addr);
        end
        bus.req1 = 0; bus.we1 = 0;
        bus.req0 = 1; bus.addr0 = 2;
        cycle();
        bus.req0 = 0;
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL rd_after_wr_grant got gnt0=%b we=%b exp 1 0", bus.gnt0, bus.mem_we);
        end
        cycle();
        cycle();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h30) begin
            errors++; $display("FAIL rd_after_wr_data got rvalid0=%b rdata0=%h exp 1 30", bus.rvalid0, bus.rdata0);
        end
        repeat (2) cycle();
    endtask

    task automatic test_lock_release();
        do_reset();
        bus.req1 = 1; bus.lock1 = 1; bus.addr1 = 3;
        cycle();
        checks++;
        if (bus.gnt1 !== 1'b1) begin errors++; $display("FAIL lock_take got gnt1=%b exp 1", bus.gnt1); end
        bus.req0 = 1; bus.addr0 = 5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL lock_block[%0d] got gnt0=%b exp 0", i, bus.gnt0); end
        end
        bus.lock1 = 0;
        cycle();
        bus.req1 = 0;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.lock_abort} !== 3'b010) begin
            errors++; $display("FAIL lock_release got gnt0/gnt1/abort=%b exp 010", {bus.gnt0, bus.gnt1, bus.lock_abort});
        end
        cycle();
        checks++;
        if ({bus.gnt0, bus.lock_abort} !== 2'b10) begin
            errors++; $display("FAIL lock_release_next got gnt0/abort=%b exp 10", {bus.gnt0, bus.lock_abort});
        end
        idle_inputs();
        repeat (3) cycle();
    endtask

    task automatic test_lock_abort();
        do_reset();
        bus.req1 = 1; bus.lock1 = 1; bus.addr1 = 3;
        cycle();
        bus.req1 = 0;
        bus.req0 = 1; bus.addr0 = 5;
        for (int i = 0; i < LOCK_MAX - 1; i++) begin
            cycle();
            checks++;
            if ({bus.gnt0, bus.lock_abort} !== 2'b00) begin
                errors++; $display("FAIL abort_hold[%0d] got gnt0/abort=%b exp 00", i, {bus.gnt0, bus.lock_abort});
            end
        end
        cycle();
        checks++;
        if ({bus.gnt0, bus.lock_abort} !== 2'b01) begin
            errors++; $display("FAIL abort_pulse got gnt0/abort=%b exp 01", {bus.gnt0, bus.lock_abort});
        end
        bus.req1 = 1; bus.lock1 = 0;
        cycle();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.lock_abort} !== 3'b100) begin
            errors++; $display("FAIL abort_gnt0 got gnt0/gnt1/abort=%b exp 100", {bus.gnt0, bus.gnt1, bus.lock_abort});
        end
        cycle();
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            errors++; $display("FAIL abort_then_gnt1 got gnt0/gnt1=%b exp 01", {bus.gnt0, bus.gnt1});
        end
        idle_inputs();
        repeat (3) cycle();
    endtask

    task automatic test_oor_reset();
        do_reset();
        bus.req1 = 1; bus.addr1 = 1;
        cycle();
        bus.req1 = 0;
        repeat (2) cycle();
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'd6) begin
            errors++; $display("FAIL oor_prior_read got rvalid1=%b rdata1=%h exp 1 6", bus.rvalid1, bus.rdata1);
        end
        bus.req1 = 1; bus.addr1 = 40;
        cycle();
        bus.req1 = 0;
        checks++;
        if ({bus.gnt1, bus.mem_en, bus.mem_we} !== 3'b100 || bus.mem_addr !== 12'd40) begin
            errors++;
            $display("FAIL oor_grant got gnt1/en/we=%b addr=%0d exp 100 40", {bus.gnt1, bus.mem_en, bus.mem_we}, bus.mem_addr);
        end
        repeat (2) cycle();
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h0) begin
            errors++; $display("FAIL oor_return got rvalid1=%b rdata1=%h exp 1 0", bus.rvalid1, bus.rdata1);
        end
        bus.req1 = 1; bus.addr1 = 1;
        cycle();
        bus.req1 = 0;
        #2 rst = 1;
        model_reset();
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we, bus.lock_abort} !== 7'b0
            || {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++; $display("FAIL async_reset got gnt1=%b rdata0=%h rdata1=%h addr=%h exp all 0",
                               bus.gnt1, bus.rdata0, bus.rdata1, bus.mem_addr);
        end
        cycle();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
                errors++; $display("FAIL reset_flush[%0d] got rvalid=%b%b exp 00", i, bus.rvalid0, bus.rvalid1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.req0   = ($urandom_range(0, 3) != 0);
            bus.addr0  = 12'($urandom_range(0, 39));
            bus.req1   = ($urandom_range(0, 3) != 0);
            bus.we1    = ($urandom_range(0, 1) == 1);
            bus.lock1  = ($urandom_range(0, 2) != 0);
            bus.addr1  = 12'($urandom_range(0, 39));
            bus.wdata1 = $urandom;
            cycle();
            checks++;
            if ({bus.gnt0, bus.gnt1} !== {m_gnt0, m_gnt1}) begin
                errors++; $display("FAIL rnd_gnt[%0d] got %b%b exp %b%b", i, bus.gnt0, bus.gnt1, m_gnt0, m_gnt1);
            end
            checks++;
            if ({bus.mem_en, bus.mem_we} !== {m_en, m_we}) begin
                errors++; $display("FAIL rnd_strobe[%0d] got %b%b exp %b%b", i, bus.mem_en, bus.mem_we, m_en, m_we);
            end
            checks++;
            if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata) begin
                errors++; $display("FAIL rnd_bus[%0d] got %h %h exp %h %h", i, bus.mem_addr, bus.mem_wdata, m_addr, m_wdata);
            end
            checks++;
            if ({bus.rvalid0, bus.rvalid1} !== {m_rv0, m_rv1}) begin
                errors++; $display("FAIL rnd_rvalid[%0d] got %b%b exp %b%b", i, bus.rvalid0, bus.rvalid1, m_rv0, m_rv1);
            end
            checks++;
            if (bus.rdata0 !== m_rdata0 || bus.rdata1 !== m_rdata1) begin
                errors++; $display("FAIL rnd_rdata[%0d] got %h %h exp %h %h", i, bus.rdata0, bus.rdata1, m_rdata0, m_rdata1);
            end
            checks++;
            if (bus.lock_abort !== m_abort) begin
                errors++; $display("FAIL rnd_abort[%0d] got %b exp %b", i, bus.lock_abort, m_abort);
            end
        end
        idle_inputs();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        test_reset();
        test_single_fetch();
        test_alternate();
        test_write_read();
        test_lock_release();
        test_lock_abort();
        test_oor_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port 32-bit unified memory between the instruction-fetch port (port 0, read-only) and the load/store port (port 1, read/write). Round-robin arbitration, one memory access per cycle, registered grants and read returns, and a bounded bus lock on port 1 for read-modify-write sequences. Sits between the processor's fetch/execute/writeback sequencer and the memory array.

## Interface
- ADDR_W, 12, address width (matches the 12-bit instruction address fields)
- DATA_W, 32, data word width
- MEM_DEPTH, 32, number of implemented words; addresses ≥ MEM_DEPTH are out of range
- LOCK_MAX, 8, maximum cycles port 1 may hold the lock
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  fetch read request; addr0 stable while high
- addr0  in  ADDR_W  fetch address
- gnt0  out  1  one-cycle grant pulse, port 0
- rvalid0  out  1  one-cycle read-data-valid pulse, port 0
- rdata0  out  DATA_W  read data, port 0; held until next port-0 return
- req1  in  1  load/store request
- we1  in  1  1 = write, 0 = read
- lock1  in  1  request/keep bus lock
- addr1  in  ADDR_W  data address
- wdata1  in  DATA_W  write data
- gnt1, rvalid1  out  1  as port 0
- rdata1  out  DATA_W  as port 0
- lock_abort  out  1  one-cycle pulse on forced lock release
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after a read mem_en

## Operation
- Eligibility at each edge: port x eligible if req_x=1 and gnt_x currently 0 (a port cannot win in the cycle its grant is high; prevents double issue while requester drops req). Port 0 additionally ineligible while lock held.
- Winner: single eligible port wins; both eligible → port not granted last wins. last reset to 1 (port 0 wins first tie).
- Grant cycle (registered): gnt_x=1, mem_addr/mem_we/mem_wdata from winner, mem_en=1 only if addr < MEM_DEPTH. Port 0 always mem_we=0.
- Out-of-range: write dropped silently; read still returns rvalid with rdata=0.
- Read return: a 2-entry pipeline tag (valid, port, in-range) follows each read grant; cycle after grant captures mem_rdata (or 0) into rdata_x; rvalid_x asserts the following cycle.
- Lock states UNLOCKED / LOCKED. UNLOCKED→LOCKED when port 1 wins with lock1=1; counter cleared. LOCKED→UNLOCKED when port 1 wins with lock1=0, or counter reaches LOCK_MAX (lock_abort pulses, last forced to 1 so port 0 wins next tie). Counter increments every LOCKED cycle.
- Idle cycles: all strobes 0; mem_addr/mem_wdata hold last values.

## Timing
- Reset (async, any time): gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, lock_abort = 0; rdata0, rdata1, mem_addr, mem_wdata = 0; last=1; UNLOCKED; counter 0; in-flight read tags discarded (no rvalid after reset release).
- req sampled at edge E0 → gnt and mem_en high E0..E1 → mem_rdata valid E1..E2 → rvalid/rdata at E2..E3. Read latency: rvalid 2 cycles after grant.
- Writes complete in grant cycle; no response.
- Throughput: one access per cycle overall; one per two cycles per port; alternating ports sustain full rate.
- Write then read to same address from different ports in consecutive cycles: read returns new data (memory in order).

## Structure
- Shared package: port index constants (PORT_FETCH=0, PORT_DATA=1), lock state encoding, read-tag struct.
- One sub-module natural: rr_arb2 (two-requester round-robin picker with last pointer and force input).

## Test plan
- Reset, mem[5]=0x32000007; req0 addr 5 → gnt0 next cycle, mem_en=1, mem_we=0, rvalid0 with rdata0=0x32000007 two cycles after grant.
- req0 and req1 (read, addr 1, mem[1]=6) held together from reset → grants alternate 0,1,0,1; each rvalid routed to correct port with correct data.
- req1 write addr 2 data 0x30 then req0 read addr 2 → mem_we pulse with mem_wdata=0x30, subsequent rdata0=0x30.
- lock1=1 with req0 held high: port 0 blocked; release via lock1=0 → port 0 granted next cycle, no lock_abort.
- Lock held, LOCK_MAX=8 → lock_abort pulses after 8 locked cycles, gnt0 follows.
- req1 read addr 40 (out of range) → gnt1, mem_en=0, rvalid1 with rdata1=0; assert rst between grant and rvalid → no rvalid, all outputs 0.
